game_sprite_display_anim: RTL

Parametrised, animated successor to the single-bitmap sprite renderer: for each scanned pixel it decides whether that pixel falls inside an axis-aligned sprite and, if so, emits the sprite's colour. The sprite is drawn from a multi-frame bitmap with arbitrary size and optional mirroring. The block sits between the VGA timing generator (`pixel_x`/`pixel_y`, one-cycle `frame_tick` per video frame) and the game's pixel mixer/collision logic, which consume `rgb_en`/`rgb` and the registered bounding box.

---
 rtl/game_sprite_display_anim.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/game_sprite_display_anim.sv
// Animated, optionally mirrored sprite renderer: registered bounding box plus a two-stage pixel pipeline.
// Optional mirroring is built only when GAME_SPRITE_DISPLAY_FLIP_EN is defined.
module game_sprite_display_anim #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int RGB_WIDTH     = 3,
  parameter int N_FRAMES      = 2,
  parameter int FRAME_PERIOD  = 8,
  parameter logic [N_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*(1+RGB_WIDTH)-1:0] BITMAP = '0,
  localparam int FRAME_W = $clog2(N_FRAMES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic [X_WIDTH-1:0]   sprite_x,
  input  logic [Y_WIDTH-1:0]   sprite_y,
  input  logic                 flip_x,
  input  logic                 flip_y,
  input  logic                 frame_tick,
  input  logic                 anim_en,
  input  logic                 anim_restart,
  output logic [FRAME_W-1:0]   frame_index,
  output logic                 sprite_within_screen,
  output logic [X_WIDTH-1:0]   sprite_out_left,
  output logic [X_WIDTH-1:0]   sprite_out_right,
  output logic [Y_WIDTH-1:0]   sprite_out_top,
  output logic [Y_WIDTH-1:0]   sprite_out_bottom,
  output logic                 rgb_en,
  output logic [RGB_WIDTH-1:0] rgb
);

  localparam int TEXEL_W = 1 + RGB_WIDTH;
  localparam int N_SLOTS = N_FRAMES * SPRITE_HEIGHT * SPRITE_WIDTH;
  localparam int BIT_W   = $clog2(N_SLOTS * TEXEL_W);
  localparam int COL_W   = (SPRITE_WIDTH > 1) ? $clog2(SPRITE_WIDTH) : 1;
  localparam int ROW_W   = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
  localparam int TICK_W  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int XE      = X_WIDTH + 1;
  localparam int YE      = Y_WIDTH + 1;

  // One extra bit keeps edges near the top of the coordinate range from wrapping.
  logic [XE-1:0] sx_ext, px_ext, right_ext;
  logic [YE-1:0] sy_ext, py_ext, bottom_ext;
  logic          within_c;
  logic          hit_c;

  assign sx_ext     = {1'b0, sprite_x};
  assign px_ext     = {1'b0, pixel_x};
  assign right_ext  = sx_ext + XE'(SPRITE_WIDTH - 1);
  assign sy_ext     = {1'b0, sprite_y};
  assign py_ext     = {1'b0, pixel_y};
  assign bottom_ext = sy_ext + YE'(SPRITE_HEIGHT - 1);

  assign within_c = ((sx_ext + XE'(SPRITE_WIDTH)) <= XE'(SCREEN_WIDTH)) &&
                    ((sy_ext + YE'(SPRITE_HEIGHT)) <= YE'(SCREEN_HEIGHT));
  assign hit_c    = (px_ext >= sx_ext) && (px_ext <= right_ext) &&
                    (py_ext >= sy_ext) && (py_ext <= bottom_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_within_screen <= 1'b0;
      sprite_out_left      <= '0;
      sprite_out_right     <= '0;
      sprite_out_top       <= '0;
      sprite_out_bottom    <= '0;
    end else begin
      sprite_within_screen <= within_c;
      sprite_out_left      <= sprite_x;
      sprite_out_right     <= right_ext[X_WIDTH-1:0];
      sprite_out_top       <= sprite_y;
      sprite_out_bottom    <= bottom_ext[Y_WIDTH-1:0];
    end
  end

  // Animation: ticks only count while enabled; restart beats a simultaneous tick.
  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (reset || anim_restart) begin
      tick_cnt    <= '0;
      frame_index <= '0;
    end else if (frame_tick && anim_en) begin
      if (tick_cnt == TICK_W'(FRAME_PERIOD - 1)) begin
        tick_cnt    <= '0;
        frame_index <= (frame_index == FRAME_W'(N_FRAMES - 1)) ? '0
                                                               : frame_index + FRAME_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Texel coordinates inside the sprite; only meaningful on a hit.
  logic [COL_W-1:0] dx, col_c;
  logic [ROW_W-1:0] dy, row_c;

  assign dx = COL_W'(pixel_x - sprite_x);
  assign dy = ROW_W'(pixel_y - sprite_y);

`ifdef GAME_SPRITE_DISPLAY_FLIP_EN
  assign col_c = flip_x ? (COL_W'(SPRITE_WIDTH - 1) - dx) : dx;
  assign row_c = flip_y ? (ROW_W'(SPRITE_HEIGHT - 1) - dy) : dy;
`else
  logic unused_flip;
  assign unused_flip = flip_x | flip_y;
  assign col_c = dx;
  assign row_c = dy;
`endif

  logic               s1_hit;
  logic [ROW_W-1:0]   s1_row;
  logic [COL_W-1:0]   s1_col;
  logic [FRAME_W-1:0] s1_frame;

  // Row/col are zeroed on a miss so the lookup never indexes outside the bitmap.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hit   <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_frame <= '0;
    end else begin
      s1_hit   <= hit_c;
      s1_row   <= hit_c ? row_c : '0;
      s1_col   <= hit_c ? col_c : '0;
      s1_frame <= frame_index;
    end
  end

  // Slot 0 is the most significant texel of the bitmap.
  logic [BIT_W-1:0]   bit_base;
  logic [TEXEL_W-1:0] texel;
  int                 slot;

  always_comb begin
    slot     = (int'(s1_frame) * SPRITE_HEIGHT + int'(s1_row)) * SPRITE_WIDTH + int'(s1_col);
    bit_base = BIT_W'((N_SLOTS - 1 - slot) * TEXEL_W);
    texel    = BITMAP[bit_base +: TEXEL_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_en <= 1'b0;
      rgb    <= '0;
    end else begin
      rgb_en <= s1_hit && texel[RGB_WIDTH];
      if (s1_hit && texel[RGB_WIDTH]) begin
        rgb <= texel[RGB_WIDTH-1:0];
      end
    end
  end

endmodule
